// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port block RAM.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed data priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy_o
);

    // state | meaning
    // ARB   | idle, choose a winner from pending requests
    // ISSUE | address presented to RAM, winner's gnt asserted
    // RESP  | RAM data valid, winner's rvalid asserted
    typedef enum logic [1:0] {ARB, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic              win_d_q, win_d_d;      // 1 = data port owns the transfer
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_d_q, last_d_d;    // 1 = data won the previous grant

    assign pick_d = d_req_i & (~if_req_i | ~last_d_q);
`else
    assign pick_d = d_req_i;
`endif

    always_comb begin
        state_d  = state_q;
        win_d_d  = win_d_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            ARB: begin
                if (if_req_i || d_req_i) begin
                    state_d = ISSUE;
                    win_d_d = pick_d;
                    we_d    = pick_d & d_we_i;
                    addr_d  = pick_d ? d_addr_i : if_addr_i;
                    wdata_d = pick_d ? d_wdata_i : '0;
                end
            end
            ISSUE: begin
                state_d  = RESP;
                we_d     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_d_d = win_d_q;
`endif
            end
            RESP: begin
                // Address/data held through RESP, cleared so idle ARB shows all-zero outputs
                state_d = ARB;
                win_d_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
            end
            default: begin
                state_d = ARB;
                win_d_d = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB;
            win_d_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            win_d_q  <= win_d_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    assign if_gnt_o    = (state_q == ISSUE) & ~win_d_q;
    assign d_gnt_o     = (state_q == ISSUE) &  win_d_q;
    assign if_rvalid_o = (state_q == RESP)  & ~win_d_q;
    assign d_rvalid_o  = (state_q == RESP)  &  win_d_q;
    assign if_rdata_o  = if_rvalid_o ? mem_data_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_data_i : '0;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = wdata_q;
    assign busy_o      = (state_q != ARB);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter; expectations follow MEM_ARB_ROUND_ROBIN_EN if defined.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    // flags = {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, busy}
    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] md;
        logic [5:0]  e_flags;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_drd;
        logic [31:0] e_ird;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] F_IDLE = 6'b000000;
    localparam logic [5:0] F_IGNT = 6'b100001;
    localparam logic [5:0] F_IRV  = 6'b010001;
    localparam logic [5:0] F_DGNT = 6'b001001;
    localparam logic [5:0] F_DRV  = 6'b000101;
    localparam logic [5:0] F_DST  = 6'b001011;

    function automatic vec_t mk(logic rst, logic ifr, logic [31:0] ifa, logic dr, logic dwe,
                                logic [31:0] da, logic [31:0] dwd, logic [31:0] md,
                                logic [5:0] ef, logic [31:0] ea, logic [31:0] ew,
                                logic [31:0] edr, logic [31:0] eir);
        vec_t v;
        v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da;
        v.dwd = dwd; v.md = md; v.e_flags = ef; v.e_addr = ea; v.e_wdata = ew;
        v.e_drd = edr; v.e_ird = eir;
        return v;
    endfunction

    function automatic logic [5:0] flags();
        return {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_we_o, busy_o};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rst_i = v.rst; if_req_i = v.ifr; if_addr_i = v.ifa; d_req_i = v.dr;
        d_we_i = v.dwe; d_addr_i = v.da; d_wdata_i = v.dwd; mem_data_i = v.md;
    endtask

    initial begin
        vec_t z;
        int waited;
        bit got;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, 0, 0);

        // single load
        vecs.push_back(z);
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h10, 0, 0, F_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, F_DGNT, 32'h10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, F_DRV, 32'h10, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, F_IDLE, 0, 0, 0, 0));
        // store
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h20, 32'h12345678, 0, F_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h20, 32'h12345678, 0, F_DST, 32'h20, 32'h12345678, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAA5555, F_DRV, 32'h20, 32'h12345678, 32'hAAAA5555, 0));
        vecs.push_back(z);
        // fetch; a request raised only in RESP must be ignored
        vecs.push_back(mk(0, 1, 32'h80000000, 0, 0, 0, 0, 0, F_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, F_IGNT, 32'h80000000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h300, 0, 0, 0, 0, 32'hCAFEF00D, F_IRV, 32'h80000000, 0, 0, 32'hCAFEF00D));
        vecs.push_back(z);
        vecs.push_back(z);
        // reset during ISSUE of a fetch
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 0, F_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, F_IGNT, 32'h100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h12, F_IDLE, 0, 0, 0, 0));
        // simultaneous held requests: gnt at relative cycles 1, 4, 7, 10
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_DGNT, 32'h40, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 32'h11, F_DRV, 32'h40, 0, 32'h11, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_IDLE, 0, 0, 0, 0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_IGNT, 32'h80000000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 32'h22, F_IRV, 32'h80000000, 0, 0, 32'h22));
`else
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_DGNT, 32'h40, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 32'h22, F_DRV, 32'h40, 0, 32'h22, 0));
`endif
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_DGNT, 32'h40, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 32'h33, F_DRV, 32'h40, 0, 32'h33, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 1, 0, 32'h40, 0, 0, F_IDLE, 0, 0, 0, 0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, F_IGNT, 32'h80000000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h44, F_IRV, 32'h80000000, 0, 0, 32'h44));
`else
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, F_DGNT, 32'h40, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h44, F_DRV, 32'h40, 0, 32'h44, 0));
`endif
        vecs.push_back(z);

        drive(z);
        rst_i = 1'b1;
        step();
        step();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            chk("flags", i, {26'd0, flags()}, {26'd0, vecs[i].e_flags});
            chk("mem_addr", i, mem_addr_o, vecs[i].e_addr);
            chk("mem_data", i, mem_data_o, vecs[i].e_wdata);
            chk("d_rdata", i, d_rdata_o, vecs[i].e_drd);
            chk("if_rdata", i, if_rdata_o, vecs[i].e_ird);
            step();
        end

        // idle for 10 cycles
        drive(z);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_flags", i, {26'd0, flags()}, 32'd0);
        end

        // held request granted within 6 cycles (fetch in RR, data in fixed priority)
        if_req_i = 1'b1; if_addr_i = 32'h500; d_req_i = 1'b1; d_addr_i = 32'h600;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 8) begin
            step();
            waited++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            got = if_gnt_o;
`else
            got = d_gnt_o;
`endif
        end
        chk("grant_bound", 0, {31'd0, got && waited <= 6}, 32'd1);
        drive(z);
        step();
        step();
        step();
        chk("after_bound_idle", 0, {26'd0, flags()}, 32'd0);

        // reset during RESP of a load aborts cleanly
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h700;
        step();
        d_req_i = 1'b0;
        chk("rst_resp_gnt", 0, {26'd0, flags()}, {26'd0, F_DGNT});
        step();
        mem_data_i = 32'h99;
        rst_i = 1'b1;
        #1;
        chk("rst_resp_rv", 0, {26'd0, flags()}, {26'd0, F_DRV});
        step();
        rst_i = 1'b0;
        #1;
        chk("rst_resp_after", 0, {26'd0, flags()}, 32'd0);
        chk("rst_resp_drd", 0, d_rdata_o, 32'd0);
        chk("rst_resp_addr", 0, mem_addr_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
